register_read_seq: RTL
======================

// Module: register_read_seq
// PURPOSE
//   Read-side sequencer for a bank of 8-bit datapath registers. It walks count consecutive addresses
//   from base_addr, issues one read strobe per word, and captures the bank's registered read data.
//   Each word goes out on a valid/ready stream. Sits between the register bank and any consumer
//   (debug dump, bus bridge), and pulses done when the burst completes.
// PARAMETERS
//   A  8  address width; addresses wrap modulo 2^A
//   D  8  data width
// PORTS
//   clk        in   1    rising-edge clock
//   reset      in   1    asynchronous, active-high reset
//   start      in   1    burst request; sampled only in IDLE
//   base_addr  in   A    first address of burst; latched on accepted start
//   count      in   A+1  number of words, 0..2^A; latched on accepted start
//   busy       out  1    high in every state except IDLE
//   rd_en      out  1    read strobe to bank; high exactly one cycle per word
//   rd_addr    out  A    address presented with rd_en (= current address register)
//   rd_data    in   D    bank read data; valid the cycle after rd_en
//   out_valid  out  1    out_data holds a word
//   out_ready  in   1    consumer accepts word when out_valid && out_ready
//   out_data   out  D    captured word
//   done       out  1    one-cycle pulse after the last word is accepted
// BEHAVIOUR
//   Reset: state=IDLE; addr, remaining, out_data=0; busy, rd_en, out_valid, done=0; rd_addr=0.
//   FSM states IDLE, ISSUE, CAPTURE, HOLD, DONE; all outputs driven from registers or state decode.
//   - IDLE: if start, addr<=base_addr, remaining<=count; count==0 -> DONE, else -> ISSUE.
//   - ISSUE: rd_en=1, rd_addr=addr; -> CAPTURE unconditionally.
//   - CAPTURE: out_data<=rd_data, out_valid<=1; -> HOLD. rd_data is sampled in no other state.
//   - HOLD: out_valid=1, out_data frozen. On out_ready: out_valid<=0, addr<=addr+1 (mod 2^A),
//     remaining<=remaining-1. remaining==1 -> DONE, else -> ISSUE. No out_ready: stay, no rd_en.
//   - DONE: done=1 for exactly one cycle; -> IDLE. busy drops in the IDLE cycle after.
//   Latency: start sampled at edge 0 -> rd_en in cycle 1 -> out_valid in cycle 3.
//   Throughput: 3 cycles/word with out_ready held high. Only one read is ever outstanding.
//   start while busy is ignored; base_addr and count do not affect an active burst.
//   count==2^A reads every address once, ending at base_addr-1.
//   Address wrap: 2^A-1 is followed by 0, with no flag.
//   out_ready while out_valid==0 has no effect.
//   Reset mid-burst (any state): immediate return to reset values. No done, and no partial word is
//   emitted afterwards.
// TESTING
//   T1 bank[i]=i*8'h11, start base=5 count=3, out_ready=1 -> rd_addr 5,6,7; out_data 55,66,77;
//      rd_en in cycles 1,4,7; one done pulse in cycle 10; busy low from cycle 11.
//   T2 base=8'hFE count=4 -> rd_addr FE,FF,00,01 in order; out_data = bank contents; one done.
//   T3 out_ready=0 for 5 cycles on first word -> out_valid and out_data=55 held stable.
//      No rd_en during the stall; the next rd_en comes 1 cycle after the accept.
//   T4 count=0 -> done pulse in cycle 1 after start; rd_en and out_valid never asserted.
//   T5 start pulsed again mid-burst with base=0 count=9 -> ignored; original 3 words only.
//   T6 reset asserted during HOLD of second word -> all outputs 0 at once, no done.
//      A new start then reads from the new base_addr.

Source files
------------

// File: rtl/register_read_seq.sv
`default_nettype none
// ============================================================================
// Module   : register_read_seq
// Purpose  : Read-side burst sequencer for a register bank. Walks `count`
//            consecutive addresses starting at `base_addr`, issues one read
//            strobe per word, captures the bank's registered read data and
//            presents each word on a valid/ready stream. Pulses `done` once
//            the final word has been accepted.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous active-high reset
//            start      - burst request, honoured only while idle
//            base_addr  - first address of the burst (A bits)
//            count      - number of words, 0..2^A (A+1 bits)
//            busy       - high whenever a burst is in progress
//            rd_en      - one-cycle read strobe per word
//            rd_addr    - address presented with rd_en
//            rd_data    - bank read data, valid the cycle after rd_en
//            out_valid  - out_data holds a word
//            out_ready  - consumer accepts the word
//            out_data   - captured word
//            done       - one-cycle pulse at burst completion
// Revision : 1.0 - initial release
// ============================================================================
module register_read_seq #(
  parameter int A = 8,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [A-1:0] base_addr,
  input  logic [A:0]   count,
  output logic         busy,
  output logic         rd_en,
  output logic [A-1:0] rd_addr,
  input  logic [D-1:0] rd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [D-1:0] out_data,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [A-1:0] addr_q, addr_d;
  // One bit wider than the address so a full 2^A-word sweep is expressible.
  logic [A:0]   remaining_q, remaining_d;
  logic [D-1:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = count;
          state_d     = (count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // The bank registers its output, so the data for the strobe issued
        // last cycle is on rd_data now; this is the only place it is sampled.
        out_data_d  = rd_data;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          addr_d      = addr_q + A'(1);  // wraps modulo 2^A
          remaining_d = remaining_q - (A+1)'(1);
          state_d     = (remaining_q == (A+1)'(1)) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign rd_en     = (state_q == S_ISSUE);
  assign rd_addr   = addr_q;
  assign done      = (state_q == S_DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
`default_nettype wire
